// File: rtl/uproc_control_unit.sv
// uproc_control_unit: fetch/decode/execute sequencer for the 8-bit uProcessor.
// Owns the accumulator and the carry/zero flags, drives the ALU controls and
// writes either ALU results into acc or acc into the external register file.
module uproc_control_unit #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [2:0]       alu_code,
  output logic             alu_ci,
  input  logic [7:0]       alu_out,
  input  logic             alu_co,
  output logic [7:0]       acc,
  output logic [IDX_W-1:0] reg_sel,
  output logic             reg_we,
  output logic [7:0]       reg_wdata,
  output logic             carry,
  output logic             zero,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  // ALU operation codes (ALU side decodes these onto its function units)
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_NOT  = 3'd5;
  localparam logic [2:0] ALU_PASS = 3'd6;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_ADC = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_SBC = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_LDR = 4'h9;
  localparam logic [3:0] OP_STR = 4'hA;
  localparam logic [3:0] OP_CLC = 4'hB;
  localparam logic [3:0] OP_SEC = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_ir;
  logic [7:0]       r_acc;
  logic             r_carry;
  logic             r_zero;
  logic [CNT_W-1:0] r_retired;

  logic [3:0]       w_op;
  logic             w_is_alu;
  logic             w_sets_carry;
  logic             w_exec;

  assign w_op   = r_ir[7:4];
  assign w_exec = (r_state == S_EXEC);

  // State register; reset returns to FETCH immediately, aborting any EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state and handshake/strobe outputs
  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    halted      = 1'b0;
    reg_we      = 1'b0;
    illegal     = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = S_EXEC;
      end
      S_EXEC: begin
        reg_we  = (w_op == OP_STR);
        illegal = (w_op == 4'hD) || (w_op == 4'hE);
        w_next  = (w_op == OP_HLT) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // ALU control decode from IR; valid in every state, only commits are gated
  always_comb begin
    alu_code     = ALU_AND;
    alu_ci       = 1'b0;
    w_is_alu     = 1'b1;
    w_sets_carry = 1'b0;
    case (w_op)
      OP_ADD: begin alu_code = ALU_ADD; w_sets_carry = 1'b1; end
      OP_ADC: begin alu_code = ALU_ADD; alu_ci = r_carry; w_sets_carry = 1'b1; end
      OP_SUB: begin alu_code = ALU_SUB; w_sets_carry = 1'b1; end
      OP_SBC: begin alu_code = ALU_SUB; alu_ci = r_carry; w_sets_carry = 1'b1; end
      OP_AND: alu_code = ALU_AND;
      OP_OR:  alu_code = ALU_OR;
      OP_XOR: alu_code = ALU_XOR;
      OP_NOT: alu_code = ALU_NOT;
      OP_LDR: alu_code = ALU_PASS;
      default: w_is_alu = 1'b0;
    endcase
  end

  // Instruction register: captured only on an accepted FETCH handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ir <= 8'h00;
    else if (r_state == S_FETCH && instr_valid) r_ir <= instr;
  end

  // Architectural state commit at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= 8'h00;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_retired <= '0;
    end else if (w_exec) begin
      r_retired <= r_retired + CNT_W'(1);
      if (w_is_alu) begin
        r_acc  <= alu_out;
        r_zero <= (alu_out == 8'h00);
        if (w_sets_carry) r_carry <= alu_co;
      end else if (w_op == OP_CLC) begin
        r_carry <= 1'b0;
      end else if (w_op == OP_SEC) begin
        r_carry <= 1'b1;
      end
    end
  end

  assign acc       = r_acc;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign retired   = r_retired;
  assign reg_sel   = r_ir[IDX_W-1:0];
  assign reg_wdata = r_acc;

endmodule

// File: tb/tb_uproc_control_unit.sv
// Bench for uproc_control_unit: behavioural ALU + register file around the DUT,
// directed scenarios followed by random instruction streams against a model.
module tb_uproc_control_unit;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_NOT  = 3'd5;
  localparam logic [2:0] ALU_PASS = 3'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  alu_code;
  logic        alu_ci;
  logic [7:0]  alu_out;
  logic        alu_co;
  logic [7:0]  acc;
  logic [3:0]  reg_sel;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic        carry;
  logic        zero;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  logic [7:0]  tb_regs [16];
  logic [7:0]  m_regs  [16];
  logic [7:0]  m_acc;
  bit          m_c, m_z, m_halt;
  int unsigned m_ret;
  logic [8:0]  alu_t;

  uproc_control_unit #(.IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_code(alu_code), .alu_ci(alu_ci),
    .alu_out(alu_out), .alu_co(alu_co), .acc(acc), .reg_sel(reg_sel),
    .reg_we(reg_we), .reg_wdata(reg_wdata), .carry(carry), .zero(zero),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: A = acc, R = register selected by reg_sel
  always_comb begin
    alu_t   = 9'd0;
    alu_out = 8'h00;
    alu_co  = 1'b0;
    case (alu_code)
      ALU_ADD:  begin alu_t = {1'b0, acc} + {1'b0, tb_regs[reg_sel]} + {8'd0, alu_ci};
                      alu_out = alu_t[7:0]; alu_co = alu_t[8]; end
      ALU_SUB:  begin alu_t = {1'b0, acc} - {1'b0, tb_regs[reg_sel]} - {8'd0, alu_ci};
                      alu_out = alu_t[7:0]; alu_co = alu_t[8]; end
      ALU_AND:  alu_out = acc & tb_regs[reg_sel];
      ALU_OR:   alu_out = acc | tb_regs[reg_sel];
      ALU_XOR:  alu_out = acc ^ tb_regs[reg_sel];
      ALU_NOT:  alu_out = ~acc;
      ALU_PASS: alu_out = tb_regs[reg_sel];
      default:  alu_out = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input int idx, input logic [7:0] val);
    tb_regs[idx] = val;
    m_regs[idx]  = val;
  endtask

  // Architectural effect of one instruction, from the instruction-set rules
  task automatic model_step(input logic [7:0] ins);
    logic [3:0] op;
    logic [7:0] r;
    int s;
    op = ins[7:4];
    r  = m_regs[ins[3:0]];
    case (op)
      4'h1, 4'h2: begin
        s = int'(m_acc) + int'(r) + ((op == 4'h2) ? int'(m_c) : 0);
        m_c = (s > 255); m_acc = s[7:0]; m_z = (m_acc == 0);
      end
      4'h3, 4'h4: begin
        s = int'(m_acc) - int'(r) - ((op == 4'h4) ? int'(m_c) : 0);
        m_c = (s < 0); m_acc = s[7:0]; m_z = (m_acc == 0);
      end
      4'h5: begin m_acc = m_acc & r; m_z = (m_acc == 0); end
      4'h6: begin m_acc = m_acc | r; m_z = (m_acc == 0); end
      4'h7: begin m_acc = m_acc ^ r; m_z = (m_acc == 0); end
      4'h8: begin m_acc = ~m_acc;    m_z = (m_acc == 0); end
      4'h9: begin m_acc = r;         m_z = (m_acc == 0); end
      4'hA: m_regs[ins[3:0]] = m_acc;
      4'hB: m_c = 1'b0;
      4'hC: m_c = 1'b1;
      4'hF: m_halt = 1'b1;
      default: ;
    endcase
    m_ret++;
  endtask

  task automatic model_reset();
    m_acc = 8'h00; m_c = 0; m_z = 0; m_halt = 0; m_ret = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Issue one instruction through the handshake and check EXEC and commit
  task automatic run(input logic [7:0] ins);
    int n;
    logic [3:0] op;
    op = ins[7:4];
    n = 0;
    while (!instr_ready && n < 8) begin @(posedge clk); #1; n++; end
    if (!instr_ready) begin check("ready_timeout", 32'd0, 32'd1); return; end
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 8'($urandom);
    check("exec_ready", instr_ready, 0);
    check("exec_reg_we", reg_we, op == 4'hA);
    check("exec_illegal", illegal, (op == 4'hD) || (op == 4'hE));
    if (op == 4'hA) begin
      check("str_sel", reg_sel, ins[3:0]);
      check("str_wdata", reg_wdata, m_acc);
      tb_regs[reg_sel] = reg_wdata;
    end
    model_step(ins);
    @(posedge clk); #1;
    check("acc", acc, m_acc);
    check("carry", carry, m_c);
    check("zero", zero, m_z);
    check("retired", retired, m_ret & 32'hFFFF);
    check("halted", halted, m_halt);
    check("ready_after", instr_ready, !m_halt);
    check("reg_we_after", reg_we, 0);
    check("illegal_after", illegal, 0);
  endtask

  initial begin
    instr = 8'h00; instr_valid = 1'b0; rst = 1'b1;
    for (int i = 0; i < 16; i++) set_reg(i, 8'h00);
    model_reset();
    @(posedge clk); #1;
    check("rst_acc", acc, 0);
    check("rst_ready", instr_ready, 1);
    check("rst_retired", retired, 0);
    check("rst_halted", halted, 0);
    check("rst_reg_we", reg_we, 0);
    rst = 1'b0;

    // Reset in the middle of an ADD's EXEC
    set_reg(1, 8'hF0); set_reg(2, 8'h20); set_reg(3, 8'h00);
    run(8'h91);
    instr = 8'h12; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst = 1'b1; #1;
    check("t1_acc", acc, 0);
    check("t1_carry", carry, 0);
    check("t1_zero", zero, 0);
    check("t1_retired", retired, 0);
    check("t1_reg_we", reg_we, 0);
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("t1_ready", instr_ready, 1);
    check("t1_acc_after", acc, 0);
    check("t1_reg_we_after", reg_we, 0);

    // LDR / ADD / ADC chain
    run(8'h91); check("t2_ldr", acc, 8'hF0);
    run(8'h12); check("t2_add", {acc, 7'd0, carry}, {8'h10, 8'h01});
    run(8'h23); check("t2_adc", {acc, 7'd0, carry}, {8'h11, 8'h00});
    check("t2_retired", retired, 3);

    // SUB / SBC borrow behaviour
    set_reg(8, 8'h05); set_reg(5, 8'h06); set_reg(6, 8'h00);
    run(8'h98);
    run(8'h35); check("t3_sub", {acc, 7'd0, carry}, {8'hFF, 8'h01});
    run(8'h46); check("t3_sbc", {acc, 7'd0, carry}, {8'hFE, 8'h00});
    run(8'hC0);
    run(8'h46); check("t3_sec_sbc", acc, 8'hFD);

    // XOR to zero, then STR
    set_reg(8, 8'h3C); set_reg(7, 8'h3C);
    run(8'h98);
    run(8'hC0);
    run(8'h77); check("t4_xor", {acc, 6'd0, zero, carry}, {8'h00, 8'h03});
    run(8'hA4); check("t4_str_reg", tb_regs[4], 8'h00);

    // Illegal opcode, then HLT with instr_valid held
    run(8'hD0);
    run(8'hF0);
    instr = 8'h11; instr_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("t5_ready", instr_ready, 0);
      check("t5_retired", retired, m_ret & 32'hFFFF);
      check("t5_acc", acc, m_acc);
    end
    instr_valid = 1'b0;
    do_reset();
    check("t5_unhalt", halted, 0);
    check("t5_ready_rst", instr_ready, 1);

    // Back-to-back ADD stream with valid held high
    set_reg(1, 8'h01);
    instr = 8'h11; instr_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("t6_ready", instr_ready, (k % 2) == 0);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    check("t6_retired", retired, 8);
    check("t6_acc", acc, 8'h08);
    m_ret = 8; m_acc = 8'h08; m_c = 0; m_z = 0;

    // Random instruction streams
    for (int i = 0; i < 16; i++) set_reg(i, 8'($urandom));
    for (int n = 0; n < 300; n++) begin
      int gap;
      logic [7:0] ins;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      ins = {4'($urandom_range(0, 14)), 4'($urandom)};
      run(ins);
    end
    run(8'hF7);
    check("rand_halted", halted, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
